msg_serializer: RTL

Unloads a packed multi-character message word, as produced by the 8-slot ASCII collection FIFO, and streams it one byte at a time to the UART transmitter over a valid/ready handshake. Slot 0 occupies the most significant byte of the packed word and is sent first. The block sits between the game/echo logic and `uart_tx`. It is the transmit-side counterpart of the receive-side FIFO that fills the packed word.

---
 rtl/msg_pkg.sv | 27 ++
 rtl/msg_serializer.sv | 102 ++++++++++
 2 files changed

// File: rtl/msg_pkg.sv
// Shared types and constants for the message serializer.
// MSG_APPEND_CRLF_EN adds a CR/LF terminator to every message.
package msg_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam int unsigned ADDR_SPACE_EXP_DEF = 3;

   // Bytes per message: one per slot, plus the terminator when enabled.
   function automatic int unsigned msg_len(input int unsigned addr_space_exp);
`ifdef MSG_APPEND_CRLF_EN
      return (1 << addr_space_exp) + 2;
`else
      return 1 << addr_space_exp;
`endif
   endfunction

   localparam int unsigned MSG_LEN = msg_len(ADDR_SPACE_EXP_DEF);

endpackage

// File: rtl/msg_serializer.sv
// Streams a packed multi-slot message out one byte at a time over valid/ready, slot 0 first.
// Optional build macro: MSG_APPEND_CRLF_EN (append 0x0D, 0x0A after the last slot).
module msg_serializer
   import msg_pkg::*;
#(
   parameter int unsigned DATA_SIZE      = 8,
   parameter int unsigned ADDR_SPACE_EXP = 3
) (
   input  logic                                          clk_100MHz,
   input  logic                                          reset,
   input  logic                                          load,
   input  logic [DATA_SIZE*(1 << ADDR_SPACE_EXP)-1:0]    msg_in,
   input  logic                                          tx_ready,
   output logic                                          tx_valid,
   output logic [DATA_SIZE-1:0]                          tx_data,
   output logic                                          busy,
   output logic                                          done
);

   localparam int unsigned W        = DATA_SIZE * (1 << ADDR_SPACE_EXP);
   localparam int unsigned CntW     = ADDR_SPACE_EXP + 1;
   localparam int unsigned MsgLen   = msg_len(ADDR_SPACE_EXP);
   localparam logic [CntW-1:0] LastIdx = CntW'(MsgLen - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    msg_q, msg_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DATA_SIZE-1:0] cur_byte;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q <= StIdle;
         msg_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               msg_d   = msg_in;
               cnt_d   = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            // load is deliberately ignored here so the message in flight is untouched
            if (tx_ready) begin
               msg_d = msg_q << DATA_SIZE;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == LastIdx) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (load) begin
               msg_d   = msg_in;
               cnt_d   = '0;
               state_d = StSend;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef MSG_APPEND_CRLF_EN
   localparam logic [CntW-1:0] CrIdx = CntW'(1 << ADDR_SPACE_EXP);

   always_comb begin
      cur_byte = msg_q[W-1 -: DATA_SIZE];
      if (cnt_q == CrIdx) begin
         cur_byte = DATA_SIZE'(ASCII_CR);
      end else if (cnt_q > CrIdx) begin
         cur_byte = DATA_SIZE'(ASCII_LF);
      end
   end
`else
   assign cur_byte = msg_q[W-1 -: DATA_SIZE];
`endif

   always_comb begin
      tx_valid = (state_q == StSend);
      busy     = (state_q == StSend);
      done     = (state_q == StDone);
      tx_data  = '0;
      if (state_q == StSend) begin
         tx_data = cur_byte;
      end
   end

endmodule
